// File: rtl/turn_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : turn_arbiter_if
// Description : Control and status bundle between a match controller and the
//               two-player turn arbiter. The master side requests matches and
//               attacks; the slave side (the arbiter) reports game state.
// Revision    : 1.0 - initial release
// ============================================================================
interface turn_arbiter_if;
    logic       start;
    logic       fire;
    logic [5:0] damage;
    logic       atk_en;
    logic       atk_strike;
    logic       turn;
    logic [6:0] hp0;
    logic [6:0] hp1;
    logic [7:0] turn_cnt;
    logic       game_over;
    logic       winner;

    modport master (
        output start,
        output fire,
        output damage,
        input  atk_en,
        input  atk_strike,
        input  turn,
        input  hp0,
        input  hp1,
        input  turn_cnt,
        input  game_over,
        input  winner
    );

    modport slave (
        input  start,
        input  fire,
        input  damage,
        output atk_en,
        output atk_strike,
        output turn,
        output hp0,
        output hp1,
        output turn_cnt,
        output game_over,
        output winner
    );
endinterface
`default_nettype wire

// File: rtl/turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : turn_arbiter
// Description : Two-player turn-based combat arbiter. The active player aims,
//               fires a strike at the attack stage, the returned damage is
//               captured and subtracted (saturating) from the opponent's HP.
//               Idle players forfeit their turn after TIMEOUT aim cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_arbiter #(
    parameter int MAX_HP  = 100,
    parameter int TIMEOUT = 200
) (
    input  wire logic     update,
    input  wire logic     rst,
    turn_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_AIM    = 3'd1,
        ST_STRIKE = 3'd2,
        ST_SETTLE = 3'd3,
        ST_APPLY  = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [6:0] c_MAX_HP       = 7'(MAX_HP);
    localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] c_CNT_MAX      = 8'd255;

    state_t     r_state;
    logic [6:0] r_hp0;
    logic [6:0] r_hp1;
    logic       r_turn;
    logic [7:0] r_turn_cnt;
    logic [7:0] r_timer;
    logic [5:0] r_dmg;
    logic       r_atk_en;
    logic       r_atk_strike;
    logic       r_game_over;
    logic       r_winner;

    state_t     w_state;
    logic [6:0] w_hp0;
    logic [6:0] w_hp1;
    logic       w_turn;
    logic [7:0] w_turn_cnt;
    logic [7:0] w_timer;
    logic [5:0] w_dmg;
    logic       w_atk_en;
    logic       w_atk_strike;
    logic       w_game_over;
    logic       w_winner;

    logic [6:0] w_opp_hp;
    logic [6:0] w_dmg_ext;
    logic [6:0] w_opp_new;

    // The opponent is whoever is not on turn; damage saturates at zero HP.
    assign w_opp_hp  = r_turn ? r_hp0 : r_hp1;
    assign w_dmg_ext = {1'b0, r_dmg};
    assign w_opp_new = (w_opp_hp > w_dmg_ext) ? (w_opp_hp - w_dmg_ext) : 7'd0;

    // State and all datapath registers; reset aborts any turn in flight.
    always_ff @(posedge update or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_hp0        <= 7'd0;
            r_hp1        <= 7'd0;
            r_turn       <= 1'b0;
            r_turn_cnt   <= 8'd0;
            r_timer      <= 8'd0;
            r_dmg        <= 6'd0;
            r_atk_en     <= 1'b0;
            r_atk_strike <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_hp0        <= w_hp0;
            r_hp1        <= w_hp1;
            r_turn       <= w_turn;
            r_turn_cnt   <= w_turn_cnt;
            r_timer      <= w_timer;
            r_dmg        <= w_dmg;
            r_atk_en     <= w_atk_en;
            r_atk_strike <= w_atk_strike;
            r_game_over  <= w_game_over;
            r_winner     <= w_winner;
        end
    end

    // Next-state and next-register values; attack-stage controls are set
    // one cycle ahead so they are registered and aligned with STRIKE/SETTLE.
    always_comb begin
        w_state      = r_state;
        w_hp0        = r_hp0;
        w_hp1        = r_hp1;
        w_turn       = r_turn;
        w_turn_cnt   = r_turn_cnt;
        w_timer      = r_timer;
        w_dmg        = r_dmg;
        w_atk_en     = 1'b0;
        w_atk_strike = 1'b0;
        w_game_over  = r_game_over;
        w_winner     = r_winner;

        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    w_hp0       = c_MAX_HP;
                    w_hp1       = c_MAX_HP;
                    w_turn      = 1'b0;
                    w_turn_cnt  = 8'd0;
                    w_timer     = 8'd0;
                    w_game_over = 1'b0;
                    w_state     = ST_AIM;
                end
            end

            ST_AIM: begin
                w_timer = r_timer + 8'd1;
                // Fire takes priority over a simultaneous timeout.
                if (bus.fire) begin
                    w_state      = ST_STRIKE;
                    w_atk_en     = 1'b1;
                    w_atk_strike = 1'b1;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_dmg   = 6'd0;
                    w_state = ST_APPLY;
                end
            end

            ST_STRIKE: begin
                w_atk_en = 1'b1;
                w_state  = ST_SETTLE;
            end

            ST_SETTLE: begin
                w_dmg   = bus.damage;
                w_state = ST_APPLY;
            end

            ST_APPLY: begin
                if (r_turn) begin
                    w_hp0 = w_opp_new;
                end else begin
                    w_hp1 = w_opp_new;
                end
                if (r_turn_cnt != c_CNT_MAX) begin
                    w_turn_cnt = r_turn_cnt + 8'd1;
                end
                if (w_opp_new == 7'd0) begin
                    w_game_over = 1'b1;
                    w_winner    = r_turn;
                    w_state     = ST_OVER;
                end else begin
                    w_turn  = ~r_turn;
                    w_timer = 8'd0;
                    w_state = ST_AIM;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign bus.atk_en     = r_atk_en;
    assign bus.atk_strike = r_atk_strike;
    assign bus.turn       = r_turn;
    assign bus.hp0        = r_hp0;
    assign bus.hp1        = r_hp1;
    assign bus.turn_cnt   = r_turn_cnt;
    assign bus.game_over  = r_game_over;
    assign bus.winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_turn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_arbiter
// Description : Directed self-checking bench for turn_arbiter (TIMEOUT=5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic strike_seen;

    turn_arbiter_if bus ();

    turn_arbiter #(
        .MAX_HP  (100),
        .TIMEOUT (5)
    ) u_dut (
        .update (clk),
        .rst    (rst_n),
        .bus    (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full fire turn: AIM -> STRIKE -> SETTLE -> APPLY -> next.
    task automatic do_fire(input logic [5:0] dmg);
        bus.fire   = 1'b1;
        bus.damage = dmg;
        step();
        bus.fire = 1'b0;
        step();
        step();
        step();
        bus.damage = 6'd0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.fire   = 1'b0;
        bus.damage = 6'd0;
        step();
        step();

        // Reset state
        chk("rst_hp0", bus.hp0, 0);
        chk("rst_hp1", bus.hp1, 0);
        chk("rst_turn", bus.turn, 0);
        chk("rst_cnt", bus.turn_cnt, 0);
        chk("rst_go", bus.game_over, 0);
        chk("rst_win", bus.winner, 0);
        chk("rst_en", bus.atk_en, 0);
        chk("rst_strike", bus.atk_strike, 0);

        // Stays idle without start
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("idle_hp0", bus.hp0, 0);

        // Start loads a fresh match
        do_start();
        chk("start_hp0", bus.hp0, 100);
        chk("start_hp1", bus.hp1, 100);
        chk("start_turn", bus.turn, 0);

        // Fire with damage 42: strike one cycle after fire, hp1=58
        bus.fire   = 1'b1;
        bus.damage = 6'd42;
        step();
        bus.fire = 1'b0;
        chk("strike_on", bus.atk_strike, 1);
        chk("en_strike", bus.atk_en, 1);
        step();
        chk("strike_off", bus.atk_strike, 0);
        chk("en_settle", bus.atk_en, 1);
        step();
        chk("en_apply", bus.atk_en, 0);
        step();
        bus.damage = 6'd0;
        chk("hit_hp1", bus.hp1, 58);
        chk("hit_hp0", bus.hp0, 100);
        chk("hit_turn", bus.turn, 1);
        chk("hit_cnt", bus.turn_cnt, 1);

        // Timeout forfeit by player 1
        strike_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            strike_seen = strike_seen | bus.atk_strike;
        end
        chk("to_turn_hold", bus.turn, 1);
        step();
        strike_seen = strike_seen | bus.atk_strike;
        chk("to_nostrike", strike_seen, 0);
        chk("to_turn", bus.turn, 0);
        chk("to_hp0", bus.hp0, 100);
        chk("to_hp1", bus.hp1, 58);
        chk("to_cnt", bus.turn_cnt, 2);

        // Fire coinciding with timer = TIMEOUT-1: fire wins
        for (int i = 0; i < 4; i++) begin
            step();
        end
        bus.fire   = 1'b1;
        bus.damage = 6'd8;
        step();
        bus.fire = 1'b0;
        chk("race_strike", bus.atk_strike, 1);
        step();
        step();
        step();
        bus.damage = 6'd0;
        chk("race_hp1", bus.hp1, 50);
        chk("race_turn", bus.turn, 1);
        chk("race_cnt", bus.turn_cnt, 3);

        // Zero damage still consumes a turn
        do_fire(6'd0);
        chk("zero_hp0", bus.hp0, 100);
        chk("zero_turn", bus.turn, 0);
        chk("zero_cnt", bus.turn_cnt, 4);

        do_fire(6'd40);
        chk("p0_hp1", bus.hp1, 10);
        do_fire(6'd30);
        chk("p1_hp0", bus.hp0, 70);
        chk("p1_turn", bus.turn, 0);

        // Lethal hit saturates at zero and ends the match
        do_fire(6'd50);
        chk("ko_hp1", bus.hp1, 0);
        chk("ko_go", bus.game_over, 1);
        chk("ko_win", bus.winner, 0);
        chk("ko_turn", bus.turn, 0);
        chk("ko_cnt", bus.turn_cnt, 7);

        // Fire ignored while over
        do_fire(6'd20);
        chk("over_hp0", bus.hp0, 70);
        chk("over_cnt", bus.turn_cnt, 7);
        chk("over_go", bus.game_over, 1);
        chk("over_en", bus.atk_en, 0);

        // Restart
        do_start();
        chk("re_hp0", bus.hp0, 100);
        chk("re_hp1", bus.hp1, 100);
        chk("re_go", bus.game_over, 0);
        chk("re_cnt", bus.turn_cnt, 0);

        // Start ignored mid-match
        do_fire(6'd7);
        bus.start = 1'b1;
        step();
        step();
        bus.start = 1'b0;
        chk("ign_hp1", bus.hp1, 93);
        chk("ign_cnt", bus.turn_cnt, 1);

        // Reset during SETTLE
        bus.fire   = 1'b1;
        bus.damage = 6'd30;
        step();
        bus.fire = 1'b0;
        step();
        chk("settle_en", bus.atk_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_en", bus.atk_en, 0);
        chk("rs_hp1", bus.hp1, 0);
        chk("rs_turn", bus.turn, 0);
        chk("rs_cnt", bus.turn_cnt, 0);
        #2;
        rst_n = 1'b1;
        step();
        step();
        step();
        bus.damage = 6'd0;
        chk("rs_idle_hp0", bus.hp0, 0);
        chk("rs_idle_hp1", bus.hp1, 0);
        chk("rs_idle_go", bus.game_over, 0);

        // Reset during STRIKE drops the strike pulse immediately
        do_start();
        bus.fire   = 1'b1;
        bus.damage = 6'd9;
        step();
        bus.fire = 1'b0;
        chk("rk_strike_on", bus.atk_strike, 1);
        rst_n = 1'b0;
        #1;
        chk("rk_strike_off", bus.atk_strike, 0);
        chk("rk_hp1", bus.hp1, 0);
        #2;
        rst_n      = 1'b1;
        bus.damage = 6'd0;
        step();

        // 256 zero-damage turns: counter saturates, turn alternates
        do_start();
        for (int i = 0; i < 256; i++) begin
            do_fire(6'd0);
            chk("sat_turn", bus.turn, 32'((i + 1) % 2));
            chk("sat_cnt", bus.turn_cnt, (i + 1 > 255) ? 255 : i + 1);
        end
        chk("sat_go", bus.game_over, 0);
        chk("sat_hp0", bus.hp0, 100);
        chk("sat_hp1", bus.hp1, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
